// File: rtl/bus_arbiter_if.sv
// Bus arbiter handshake bundle: active-low request/grant pairs for four masters
// plus the registered owner index and idle flag that steer the bus multiplexer.
interface bus_arbiter_if;
  logic       M0BusReq_;
  logic       M1BusReq_;
  logic       M2BusReq_;
  logic       M3BusReq_;
  logic       M0BusGrnt_;
  logic       M1BusGrnt_;
  logic       M2BusGrnt_;
  logic       M3BusGrnt_;
  logic [1:0] BusOwner;
  logic       BusIdle;

  // Arbiter side.
  modport slave (
    input  M0BusReq_, M1BusReq_, M2BusReq_, M3BusReq_,
    output M0BusGrnt_, M1BusGrnt_, M2BusGrnt_, M3BusGrnt_, BusOwner, BusIdle
  );

  // Requesting masters' side.
  modport master (
    output M0BusReq_, M1BusReq_, M2BusReq_, M3BusReq_,
    input  M0BusGrnt_, M1BusGrnt_, M2BusGrnt_, M3BusGrnt_, BusOwner, BusIdle
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-master bus arbiter. Grants are registered, held while the owner keeps
// requesting (no pre-emption) and handed off to the next requester with no
// bubble cycle. Selection is fixed priority M0 > M1 > M2 > M3 by default;
// defining BUS_ARB_RR_EN switches to round-robin starting after LastOwner.
module bus_arbiter #(
  parameter int unsigned IDLE_OWNER = 0
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);

  localparam logic [1:0] IdleOwner = 2'(IDLE_OWNER);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;        // active-high internally
  logic [1:0] bus_owner_q, bus_owner_d;
  logic       bus_idle_q, bus_idle_d;
  logic [1:0] last_owner_q, last_owner_d;

  logic [3:0] req;
  logic [3:0] cand;
  logic [1:0] start;
  logic [1:0] winner;

  // First requester in cand, searching upward from start and wrapping 3 -> 0.
  function automatic logic [1:0] pick(input logic [3:0] c, input logic [1:0] s);
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    win   = s;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = s + 2'(i);
      if (!found && c[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign req = ~{bus.M3BusReq_, bus.M2BusReq_, bus.M1BusReq_, bus.M0BusReq_};

  // Candidate set, search origin and winner for this edge.
  always_comb begin
    cand = req;
    if (state_q == StOwned) begin
      // The old owner never wins the handoff it is releasing.
      cand[bus_owner_q] = 1'b0;
    end
`ifdef BUS_ARB_RR_EN
    start = last_owner_q + 2'd1;
`else
    start = 2'd0;
`endif
    winner = pick(cand, start);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    bus_owner_d  = bus_owner_q;
    bus_idle_d   = bus_idle_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (|cand) begin
          state_d      = StOwned;
          grant_d      = 4'b0001 << winner;
          bus_owner_d  = winner;
          bus_idle_d   = 1'b0;
          last_owner_d = winner;
        end
      end
      StOwned: begin
        if (!req[bus_owner_q]) begin
          if (|cand) begin
            grant_d      = 4'b0001 << winner;
            bus_owner_d  = winner;
            last_owner_d = winner;
          end else begin
            state_d     = StIdle;
            grant_d     = 4'b0000;
            bus_owner_d = IdleOwner;
            bus_idle_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        grant_d     = 4'b0000;
        bus_owner_d = IdleOwner;
        bus_idle_d  = 1'b1;
      end
    endcase
  end

  // State registers; reset drops any grant immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= 4'b0000;
      bus_owner_q  <= IdleOwner;
      bus_idle_q   <= 1'b1;
      last_owner_q <= 2'd3;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      bus_owner_q  <= bus_owner_d;
      bus_idle_q   <= bus_idle_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign bus.M0BusGrnt_ = ~grant_q[0];
  assign bus.M1BusGrnt_ = ~grant_q[1];
  assign bus.M2BusGrnt_ = ~grant_q[2];
  assign bus.M3BusGrnt_ = ~grant_q[3];
  assign bus.BusOwner   = bus_owner_q;
  assign bus.BusIdle    = bus_idle_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected post-edge outputs
// from a behavioural model; a monitor pops and compares one cycle later.
module tb_bus_arbiter;

  localparam int unsigned IdleOwner = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_arbiter_if bus ();

  bus_arbiter #(
    .IDLE_OWNER(IdleOwner)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0] grnt_n;
    logic [1:0] owner;
    logic       idle;
  } exp_t;

  exp_t  exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  string phase       = "init";

  // Reference model: owner index (-1 when idle) and last winner.
  int m_owner = -1;
  int m_last  = 3;

  function automatic int m_select(input logic [3:0] c);
`ifdef BUS_ARB_RR_EN
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = (m_last + i) % 4;
      if (c[idx]) return idx;
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (c[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic void m_step(input logic [3:0] r);
    logic [3:0] c;
    if (m_owner < 0) begin
      if (r != 4'b0000) begin
        m_owner = m_select(r);
        m_last  = m_owner;
      end
    end else if (!r[m_owner]) begin
      c          = r;
      c[m_owner] = 1'b0;
      if (c != 4'b0000) begin
        m_owner = m_select(c);
        m_last  = m_owner;
      end else begin
        m_owner = -1;
      end
    end
  endfunction

  function automatic void m_reset();
    m_owner = -1;
    m_last  = 3;
  endfunction

  function automatic exp_t m_outputs();
    exp_t e;
    e.grnt_n = 4'hF;
    if (m_owner >= 0) begin
      e.grnt_n[m_owner] = 1'b0;
      e.owner           = 2'(m_owner);
      e.idle            = 1'b0;
    end else begin
      e.owner = 2'(IdleOwner);
      e.idle  = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a.grnt_n = {bus.M3BusGrnt_, bus.M2BusGrnt_, bus.M1BusGrnt_, bus.M0BusGrnt_};
    a.owner  = bus.BusOwner;
    a.idle   = bus.BusIdle;
    return a;
  endfunction

  function automatic void check(input string name, input exp_t act, input exp_t e);
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s/%s t=%0t: got grnt_n=%b owner=%0d idle=%b, want grnt_n=%b owner=%0d idle=%b",
               phase, name, $time, act.grnt_n, act.owner, act.idle, e.grnt_n, e.owner, e.idle);
    end
  endfunction

  // Exclusivity and owner/grant consistency, independent of the model.
  function automatic void check_invariant(input exp_t act);
    int zeros;
    int idx;
    zeros = 0;
    idx   = 0;
    for (int i = 0; i < 4; i++) begin
      if (act.grnt_n[i] == 1'b0) begin
        zeros++;
        idx = i;
      end
    end
    vectors++;
    if (zeros > 1 || (zeros == 1 && int'(act.owner) != idx) || (act.idle != (zeros == 0))) begin
      miscompares++;
      $display("FAIL %s/exclusive t=%0t: got grnt_n=%b owner=%0d idle=%b, want <=1 low grant matching owner",
               phase, $time, act.grnt_n, act.owner, act.idle);
    end
  endfunction

  task automatic drive(input logic [3:0] r);
    bus.M0BusReq_ = ~r[0];
    bus.M1BusReq_ = ~r[1];
    bus.M2BusReq_ = ~r[2];
    bus.M3BusReq_ = ~r[3];
  endtask

  // Drive requests for the next edge, record the expected result, advance.
  task automatic cycle(input logic [3:0] r);
    drive(r);
    m_step(r);
    exp_q.push_back(m_outputs());
    @(posedge clk);
    #2;
  endtask

  // Everyone requests; each owner drops after 2 granted cycles; M0 re-requests once.
  task automatic run_contention();
    logic [3:0] want;
    int         held;
    int         prev;
    bit         pending;
    bit         rereq_done;
    bit         done;
    want       = 4'hF;
    held       = 0;
    pending    = 1'b0;
    rereq_done = 1'b0;
    done       = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      if (pending) begin
        want[0]    = 1'b1;
        pending    = 1'b0;
        rereq_done = 1'b1;
      end
      if (m_owner >= 0 && held >= 2) begin
        want[m_owner] = 1'b0;
        if (m_owner == 0 && !rereq_done) pending = 1'b1;
      end
      prev = m_owner;
      cycle(want);
      if (m_owner >= 0) held = (m_owner != prev) ? 1 : held + 1;
      else held = 0;
      if (want == 4'b0000 && m_owner < 0 && !pending) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL contention_timeout: got unfinished after 40 cycles, want all masters served");
    end
  endtask

  // Monitor: compare outputs 1 time unit after each rising edge.
  initial begin
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        act = sample();
        check("scoreboard", act, exp_q.pop_front());
        check_invariant(act);
      end
    end
  end

  initial begin
    logic [3:0] r;
    reset = 1'b1;
    drive(4'b0000);
    m_reset();
    repeat (2) @(posedge clk);
    #2;
    phase = "reset";
    check("reset_values", sample(), m_outputs());
    reset = 1'b0;

    phase = "idle";
    repeat (5) cycle(4'b0000);

    phase = "single";
    repeat (4) cycle(4'b0010);
    repeat (2) cycle(4'b0000);

    phase = "contention";
    run_contention();
    repeat (2) cycle(4'b0000);

    phase = "wrap";
    repeat (2) cycle(4'b1000);
    repeat (2) cycle(4'b1101);
    repeat (2) cycle(4'b0101);
    repeat (2) cycle(4'b0000);

    phase = "reset_mid";
    repeat (2) cycle(4'b0100);
    #3;
    reset = 1'b1;
    #1;
    m_reset();
    exp_q.delete();
    check("async_drop", sample(), m_outputs());
    @(posedge clk);
    #4;
    check("held_in_reset", sample(), m_outputs());
    reset = 1'b0;
    repeat (2) cycle(4'b0100);
    repeat (2) cycle(4'b0000);

    phase = "random";
    r = 4'b0000;
    repeat (10000) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      end
      cycle(r);
    end
    cycle(4'b0000);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
